i2c_init_sequencer: RTL and testbench

Autonomous configuration sequencer placed in front of the I2C master: on a single `start` pulse it walks a 16-bit-per-entry register table and issues one I2C register write per entry, inserting programmable delays, retrying NACKed transfers and stopping at an end marker. It owns the master's write port during a run, so cores and accelerators do not need to bring up peripherals (for example camera sensors) with one custom instruction per register. Result reporting is `done` and `error` only; no data is read back.

---
 rtl/i2c_init_pkg.sv | 46 ++++
 rtl/i2c_init_rom.sv | 40 ++++
 rtl/i2c_init_sequencer.sv | 216 +++++++++++++++++++++
 tb/tb_i2c_init_sequencer.sv | 501 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_init_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2c_init_pkg
// Purpose  : Shared types and constants for the I2C init sequencer: FSM state
//            encoding, table-entry classification and the entry decoder.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package i2c_init_pkg;

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_FETCH       = 3'd1,
        S_DECODE      = 3'd2,
        S_ISSUE       = 3'd3,
        S_WAIT_ACCEPT = 3'd4,
        S_WAIT_DONE   = 3'd5,
        S_DELAY       = 3'd6,
        S_FINISH      = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        E_WRITE = 2'd0,
        E_DELAY = 2'd1,
        E_END   = 2'd2
    } entry_kind_t;

    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [7:0]  DELAY_REG  = 8'hF0;

    // The end marker is checked first: its register byte is 0xFF, so it can
    // never be confused with a delay entry, but it must win over "write".
    function automatic entry_kind_t decode_entry(input logic [15:0] word);
        entry_kind_t kind;
        if (word == END_MARKER) begin
            kind = E_END;
        end else if (word[15:8] == DELAY_REG) begin
            kind = E_DELAY;
        end else begin
            kind = E_WRITE;
        end
        return kind;
    endfunction

endpackage
`default_nettype wire

// File: rtl/i2c_init_rom.sv
`default_nettype none
// ============================================================================
// Module   : i2c_init_rom
// Purpose  : Synchronous NR_OF_ENTRIES x 16 register table for the init
//            sequencer, one-cycle read latency. Entry i lives at
//            TABLE[16*i +: 16]; the board build turns its register hex file
//            into this parameter so tables can be swapped per board without
//            touching the sequencer.
// Ports    : clock      - system clock
//            i_address  - table read address
//            o_data     - table word {reg, data}, valid one cycle later
// Revision : 1.0 - initial release
// ============================================================================
module i2c_init_rom
    import i2c_init_pkg::*;
#(
    parameter int                           NR_OF_ENTRIES = 64,
    parameter int                           ADDR_W        = $clog2(NR_OF_ENTRIES),
    parameter logic [NR_OF_ENTRIES*16-1:0]  TABLE         = {NR_OF_ENTRIES{END_MARKER}}
) (
    input  logic              clock,
    input  logic [ADDR_W-1:0] i_address,
    output logic [15:0]       o_data
);

    logic [15:0] w_entries [NR_OF_ENTRIES];
    logic [15:0] r_data;

    for (genvar gi = 0; gi < NR_OF_ENTRIES; gi++) begin : g_entries
        assign w_entries[gi] = TABLE[gi*16 +: 16];
    end

    always_ff @(posedge clock) begin
        r_data <= w_entries[i_address];
    end

    assign o_data = r_data;

endmodule
`default_nettype wire

// File: rtl/i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : i2c_init_sequencer
// Purpose  : Walks a register table and issues one I2C register write per
//            entry through the I2C master's write port, with programmable
//            delays, NACK retries and an end marker. Reports done/error only.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            start                 - begin a run (sampled in IDLE only)
//            busy, done, error     - run status; error is sticky
//            errorIndex            - index of the failing entry
//            romAddress, romData   - synchronous table read port
//            i2cStartWrite         - one-cycle start pulse to the master
//            i2cAddress            - constant device address
//            i2cRegister, i2cData  - bytes of the current write
//            i2cBusy, i2cAckError  - master status
// Revision : 1.0 - initial release
// ============================================================================
module i2c_init_sequencer
    import i2c_init_pkg::*;
#(
    parameter int         NR_OF_ENTRIES     = 64,
    parameter int         ADDR_W            = $clog2(NR_OF_ENTRIES),
    parameter logic [6:0] DEVICE_ADDRESS    = 7'h21,
    parameter int         MAX_RETRIES       = 3,
    parameter int         DELAY_UNIT_CYCLES = 12000,
    parameter int         ACCEPT_TIMEOUT    = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W-1:0] errorIndex,
    output logic [ADDR_W-1:0] romAddress,
    input  logic [15:0]       romData,
    output logic              i2cStartWrite,
    output logic [6:0]        i2cAddress,
    output logic [7:0]        i2cRegister,
    output logic [7:0]        i2cData,
    input  logic              i2cBusy,
    input  logic              i2cAckError
);

    localparam int                  c_DLY_W      = $clog2(255*DELAY_UNIT_CYCLES+1);
    localparam int                  c_TMO_W      = $clog2(ACCEPT_TIMEOUT+1);
    localparam logic [c_DLY_W-1:0]  c_DLY_UNIT   = c_DLY_W'(DELAY_UNIT_CYCLES);
    // The ISSUE cycle and the final WAIT_ACCEPT cycle both count toward the
    // timeout, so done lands exactly ACCEPT_TIMEOUT cycles after the pulse.
    localparam logic [c_TMO_W-1:0]  c_TMO_LOAD   = c_TMO_W'(ACCEPT_TIMEOUT-2);
    localparam logic [ADDR_W-1:0]   c_LAST_INDEX = ADDR_W'(NR_OF_ENTRIES-1);
    localparam logic [3:0]          c_MAX_RETRY  = 4'(MAX_RETRIES);

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic [3:0]          r_retry;
    logic [c_DLY_W-1:0]  r_delay;
    logic [c_TMO_W-1:0]  r_timeout;
    logic                r_busy;
    logic                r_done;
    logic                r_error;
    logic [ADDR_W-1:0]   r_error_index;
    logic [ADDR_W-1:0]   r_rom_address;
    logic                r_start_write;
    logic [7:0]          r_register;
    logic [7:0]          r_data;

    entry_kind_t         w_kind;
    logic [c_DLY_W-1:0]  w_delay_load;
    logic                w_last;
    logic [ADDR_W-1:0]   w_index_next;

    assign w_kind       = decode_entry(romData);
    assign w_delay_load = c_DLY_W'(romData[7:0]) * c_DLY_UNIT;
    assign w_last       = (r_index == c_LAST_INDEX);
    assign w_index_next = r_index + 1'b1;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_index       <= '0;
            r_retry       <= '0;
            r_delay       <= '0;
            r_timeout     <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_error_index <= '0;
            r_rom_address <= '0;
            r_start_write <= 1'b0;
            r_register    <= '0;
            r_data        <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state       <= S_FETCH;
                        r_busy        <= 1'b1;
                        r_index       <= '0;
                        r_retry       <= '0;
                        r_error       <= 1'b0;
                        r_error_index <= '0;
                        r_rom_address <= '0;
                    end
                end

                // Address is already on romAddress; the table answers next cycle.
                S_FETCH: begin
                    r_state <= S_DECODE;
                end

                S_DECODE: begin
                    case (w_kind)
                        E_END: begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end
                        E_DELAY: begin
                            r_state <= S_DELAY;
                            r_delay <= w_delay_load;
                        end
                        default: begin
                            r_state       <= S_ISSUE;
                            r_register    <= romData[15:8];
                            r_data        <= romData[7:0];
                            r_start_write <= 1'b1;
                        end
                    endcase
                end

                S_ISSUE: begin
                    r_state       <= S_WAIT_ACCEPT;
                    r_start_write <= 1'b0;
                    r_timeout     <= c_TMO_LOAD;
                end

                S_WAIT_ACCEPT: begin
                    if (i2cBusy) begin
                        r_state <= S_WAIT_DONE;
                    end else if (r_timeout == '0) begin
                        r_state       <= S_FINISH;
                        r_done        <= 1'b1;
                        r_error       <= 1'b1;
                        r_error_index <= r_index;
                    end else begin
                        r_timeout <= r_timeout - 1'b1;
                    end
                end

                S_WAIT_DONE: begin
                    if (!i2cBusy) begin
                        if (!i2cAckError) begin
                            r_retry <= '0;
                            if (w_last) begin
                                r_state <= S_FINISH;
                                r_done  <= 1'b1;
                            end else begin
                                r_state       <= S_FETCH;
                                r_index       <= w_index_next;
                                r_rom_address <= w_index_next;
                            end
                        end else if (r_retry < c_MAX_RETRY) begin
                            r_state       <= S_ISSUE;
                            r_retry       <= r_retry + 1'b1;
                            r_start_write <= 1'b1;
                        end else begin
                            r_state       <= S_FINISH;
                            r_done        <= 1'b1;
                            r_error       <= 1'b1;
                            r_error_index <= r_index;
                        end
                    end
                end

                S_DELAY: begin
                    if (r_delay == '0) begin
                        r_retry <= '0;
                        if (w_last) begin
                            r_state <= S_FINISH;
                            r_done  <= 1'b1;
                        end else begin
                            r_state       <= S_FETCH;
                            r_index       <= w_index_next;
                            r_rom_address <= w_index_next;
                        end
                    end else begin
                        r_delay <= r_delay - 1'b1;
                    end
                end

                // busy stays high through the done cycle and drops afterwards.
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy          = r_busy;
    assign done          = r_done;
    assign error         = r_error;
    assign errorIndex    = r_error_index;
    assign romAddress    = r_rom_address;
    assign i2cStartWrite = r_start_write;
    assign i2cAddress    = DEVICE_ADDRESS;
    assign i2cRegister   = r_register;
    assign i2cData       = r_data;

endmodule
`default_nettype wire

// File: tb/tb_i2c_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2c_init_sequencer
// Purpose  : Self-checking bench for i2c_init_sequencer with a table model,
//            a configurable ACK/NACK I2C master model and a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_init_sequencer;

    localparam int NR     = 64;
    localparam int ADDR_W = 6;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              error;
    logic [ADDR_W-1:0] errorIndex;
    logic [ADDR_W-1:0] romAddress;
    logic [15:0]       romData;
    logic              i2cStartWrite;
    logic [6:0]        i2cAddress;
    logic [7:0]        i2cRegister;
    logic [7:0]        i2cData;
    logic              i2cBusy;
    logic              i2cAckError;

    i2c_init_sequencer #(
        .NR_OF_ENTRIES     (NR),
        .DEVICE_ADDRESS    (7'h21),
        .MAX_RETRIES       (3),
        .DELAY_UNIT_CYCLES (10),
        .ACCEPT_TIMEOUT    (16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .busy          (busy),
        .done          (done),
        .error         (error),
        .errorIndex    (errorIndex),
        .romAddress    (romAddress),
        .romData       (romData),
        .i2cStartWrite (i2cStartWrite),
        .i2cAddress    (i2cAddress),
        .i2cRegister   (i2cRegister),
        .i2cData       (i2cData),
        .i2cBusy       (i2cBusy),
        .i2cAckError   (i2cAckError)
    );

    always #5 clock = ~clock;

    // Table model: synchronous read, one cycle latency.
    logic [15:0] rom_mem [NR];
    always @(posedge clock) romData <= rom_mem[romAddress];

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Master model: busy for 4 cycles after a pulse; NACKs a register while
    // its attempt count in this run is below nack_plan[reg].
    bit   accept_en = 1'b1;
    int   nack_plan [256];
    int   attempts  [256];
    int   m_cnt;
    logic m_nack;
    always @(posedge clock) begin
        if (reset) begin
            i2cBusy     <= 1'b0;
            i2cAckError <= 1'b0;
            m_cnt       <= 0;
            m_nack      <= 1'b0;
        end else begin
            i2cAckError <= 1'b0;
            if (i2cBusy) begin
                if (m_cnt == 0) begin
                    i2cBusy     <= 1'b0;
                    i2cAckError <= m_nack;
                end else begin
                    m_cnt <= m_cnt - 1;
                end
            end else if (i2cStartWrite && accept_en) begin
                i2cBusy <= 1'b1;
                m_cnt   <= 3;
                m_nack  <= (attempts[i2cRegister] < nack_plan[i2cRegister]);
                attempts[i2cRegister] <= attempts[i2cRegister] + 1;
            end
            if (start && !busy) begin
                for (int k = 0; k < 256; k++) attempts[k] <= 0;
            end
        end
    end

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] exp_q [$];
    logic [15:0] obs_q [$];
    int          obs_cyc [$];
    int          nack_cyc [$];
    int          t0;
    int          done_cnt;
    int          done_cyc;
    logic        done_err;
    logic [5:0]  done_eidx;
    bit          wrapped;
    bit          unstable;
    logic [15:0] exp_w;
    logic [15:0] obs_w;

    // Samples the DUT on falling edges, optionally pulsing start on
    // iteration 0 and/or iteration start_at, until done plus tail cycles.
    task automatic run_capture(input bit do_start, input int start_at, input int budget, input int tail);
        int          after;
        logic [5:0]  prev;
        logic [15:0] last_rd;
        after   = -1;
        prev    = romAddress;
        last_rd = '0;
        obs_q.delete(); obs_cyc.delete(); nack_cyc.delete();
        done_cnt = 0; done_cyc = -1; wrapped = 0; unstable = 0;
        done_err = 1'bx; done_eidx = 'x;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (i2cStartWrite === 1'b1) begin
                last_rd = {i2cRegister, i2cData};
                obs_q.push_back(last_rd);
                obs_cyc.push_back(cyc);
            end else if (i2cBusy === 1'b1 && {i2cRegister, i2cData} !== last_rd) begin
                unstable = 1;
            end
            if (i2cBusy === 1'b0 && i2cAckError === 1'b1) nack_cyc.push_back(cyc);
            if (done === 1'b1) begin
                done_cnt++;
                if (after < 0) begin
                    after     = tail;
                    done_cyc  = cyc;
                    done_err  = error;
                    done_eidx = errorIndex;
                end
            end
            if (i > 1 && busy === 1'b1 && prev != 0 && romAddress == 0) wrapped = 1;
            prev  = romAddress;
            start = (i == 0 && do_start) || (i == start_at);
            if (i == 0) t0 = cyc;
            if (after >= 0) begin
                if (after == 0) begin
                    start = 1'b0;
                    return;
                end
                after--;
            end
        end
        start = 1'b0;
    endtask

    task automatic load_table(input logic [15:0] words [$]);
        for (int i = 0; i < NR; i++) rom_mem[i] = 16'hFFFF;
        foreach (words[i]) rom_mem[i] = words[i];
    endtask

    task automatic test_reset();
        @(negedge clock);
        n_checks++;
        if ({busy, done, error, errorIndex, romAddress, i2cStartWrite, i2cRegister, i2cData} !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b error=%b eidx=%0d addr=%0d sw=%b reg=%h data=%h, expected all 0",
                     busy, done, error, errorIndex, romAddress, i2cStartWrite, i2cRegister, i2cData);
        end
        n_checks++;
        if (i2cAddress !== 7'h21) begin
            n_errors++;
            $display("FAIL reset_i2c_address: got %h, expected 21", i2cAddress);
        end
    endtask

    task automatic test_end_marker();
        logic [2:0] exp_s [4];
        exp_s = '{3'b100, 3'b100, 3'b110, 3'b000};
        load_table('{16'hFFFF});
        @(negedge clock) start = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock) start = 1'b0;
            n_checks++;
            if ({busy, done, i2cStartWrite} !== exp_s[k]) begin
                n_errors++;
                $display("FAIL end_marker_t%0d: busy/done/startWrite=%b, expected %b", k + 1, {busy, done, i2cStartWrite}, exp_s[k]);
            end
        end
    endtask

    task automatic test_basic_writes();
        load_table('{16'h1280, 16'h1101, 16'hFFFF});
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        run_capture(1, -1, 200, 5);
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            n_errors++;
            $display("FAIL basic_done: done pulses=%0d error=%b, expected 1 and 0", done_cnt, done_err);
        end
        n_checks++;
        if (obs_cyc.size() == 0 || obs_cyc[0] - t0 != 3) begin
            n_errors++;
            $display("FAIL basic_first_pulse: latency=%0d, expected 3", obs_cyc.size() ? obs_cyc[0] - t0 : -1);
        end
        n_checks++;
        if (unstable) begin
            n_errors++;
            $display("FAIL basic_stable: reg/data changed during transfer, expected stable");
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL basic_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL basic_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL basic_extra: %0d extra pulses, expected 0", obs_q.size());
        end
    endtask

    task automatic test_delay();
        int gap;
        load_table('{16'hF003, 16'h1234, 16'hFFFF});
        exp_q.push_back(16'h1234);
        run_capture(1, -1, 300, 5);
        gap = obs_cyc.size() ? obs_cyc[0] - (t0 + 2) : -1;
        n_checks++;
        if (gap < 30 || gap > 34) begin
            n_errors++;
            $display("FAIL delay_gap: pulse %0d cycles after DECODE, expected 30..34", gap);
        end
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            n_errors++;
            $display("FAIL delay_done: done pulses=%0d error=%b, expected 1 and 0", done_cnt, done_err);
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL delay_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL delay_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL delay_extra: %0d extra pulses, expected 0", obs_q.size());
        end
    endtask

    task automatic test_retry();
        load_table('{16'h1280, 16'h1101, 16'hFFFF});
        nack_plan[8'h11] = 2;
        exp_q.push_back(16'h1280);
        repeat (3) exp_q.push_back(16'h1101);
        run_capture(1, -1, 300, 5);
        nack_plan[8'h11] = 0;
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            n_errors++;
            $display("FAIL retry_done: done pulses=%0d error=%b, expected 1 and 0", done_cnt, done_err);
        end
        n_checks++;
        if (nack_cyc.size() != 2 || obs_cyc.size() < 3 || obs_cyc[2] != nack_cyc[0] + 1) begin
            n_errors++;
            $display("FAIL retry_repulse: nacks=%0d pulses=%0d, expected 2 nacks and re-pulse 1 cycle after first nack",
                     nack_cyc.size(), obs_cyc.size());
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL retry_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL retry_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL retry_extra: %0d extra pulses, expected 0", obs_q.size());
        end
    endtask

    task automatic test_retry_exhausted();
        load_table('{16'h1280, 16'h1101, 16'h1322, 16'hFFFF});
        nack_plan[8'h13] = 100;
        exp_q.push_back(16'h1280);
        exp_q.push_back(16'h1101);
        repeat (4) exp_q.push_back(16'h1322);
        run_capture(1, -1, 400, 5);
        nack_plan[8'h13] = 0;
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b1 || done_eidx !== 6'd2) begin
            n_errors++;
            $display("FAIL exhausted_done: done pulses=%0d error=%b eidx=%0d, expected 1, 1, 2", done_cnt, done_err, done_eidx);
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL exhausted_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL exhausted_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL exhausted_extra: %0d extra pulses, expected 0", obs_q.size());
        end
        // Sticky until the next accepted start, which clears it at once.
        load_table('{16'hFFFF});
        @(negedge clock);
        n_checks++;
        if (error !== 1'b1) begin
            n_errors++;
            $display("FAIL error_sticky: error=%b, expected 1", error);
        end
        start = 1'b1;
        @(negedge clock) start = 1'b0;
        n_checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL error_clear: error=%b busy=%b, expected 0 and 1", error, busy);
        end
        run_capture(0, -1, 20, 2);
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            n_errors++;
            $display("FAIL error_clear_done: done pulses=%0d error=%b, expected 1 and 0", done_cnt, done_err);
        end
    endtask

    task automatic test_timeout_ignored_start();
        load_table('{16'h1280, 16'hFFFF});
        accept_en = 1'b0;
        exp_q.push_back(16'h1280);
        run_capture(1, 8, 80, 25);
        accept_en = 1'b1;
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b1 || done_eidx !== 6'd0) begin
            n_errors++;
            $display("FAIL timeout_done: done pulses=%0d error=%b eidx=%0d, expected 1, 1, 0", done_cnt, done_err, done_eidx);
        end
        n_checks++;
        if (obs_cyc.size() == 0 || done_cyc - obs_cyc[0] != 16) begin
            n_errors++;
            $display("FAIL timeout_latency: done %0d cycles after pulse, expected 16",
                     obs_cyc.size() ? done_cyc - obs_cyc[0] : -1);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL ignored_start_busy: busy=%b, expected 0", busy);
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL timeout_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL timeout_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL ignored_start_extra: %0d extra pulses, expected 0", obs_q.size());
        end
    endtask

    task automatic test_full_table();
        for (int i = 0; i < NR; i++) begin
            rom_mem[i] = {8'(i), 8'(i) ^ 8'h5A};
            exp_q.push_back({8'(i), 8'(i) ^ 8'h5A});
        end
        run_capture(1, -1, 3000, 5);
        n_checks++;
        if (done_cnt !== 1 || done_err !== 1'b0) begin
            n_errors++;
            $display("FAIL full_done: done pulses=%0d error=%b, expected 1 and 0", done_cnt, done_err);
        end
        n_checks++;
        if (wrapped || romAddress !== 6'd63) begin
            n_errors++;
            $display("FAIL full_no_wrap: wrapped=%0d final addr=%0d, expected 0 and 63", wrapped, romAddress);
        end
        while (exp_q.size() > 0) begin
            exp_w = exp_q.pop_front();
            n_checks++;
            if (obs_q.size() == 0) begin
                n_errors++;
                $display("FAIL full_write: no pulse, expected reg/data %h", exp_w);
            end else begin
                obs_w = obs_q.pop_front();
                if (obs_w !== exp_w) begin
                    n_errors++;
                    $display("FAIL full_write: reg/data %h, expected %h", obs_w, exp_w);
                end
            end
        end
        n_checks++;
        if (obs_q.size() != 0) begin
            n_errors++;
            $display("FAIL full_extra: %0d extra pulses, expected 0", obs_q.size());
        end
    endtask

    task automatic test_reset_mid_run();
        int waited;
        int stray;
        load_table('{16'h1280, 16'hFFFF});
        @(negedge clock) start = 1'b1;
        @(negedge clock) start = 1'b0;
        waited = 0;
        while (i2cBusy !== 1'b1 && waited < 20) begin
            @(negedge clock);
            waited++;
        end
        n_checks++;
        if (i2cBusy !== 1'b1) begin
            n_errors++;
            $display("FAIL midrun_reach: i2cBusy=%b after %0d cycles, expected 1", i2cBusy, waited);
        end
        @(negedge clock) reset = 1'b1;
        @(negedge clock) reset = 1'b0;
        n_checks++;
        if ({busy, done, error, errorIndex, romAddress, i2cStartWrite, i2cRegister, i2cData} !== '0) begin
            n_errors++;
            $display("FAIL midrun_outputs: got busy=%b done=%b error=%b eidx=%0d addr=%0d sw=%b reg=%h data=%h, expected all 0",
                     busy, done, error, errorIndex, romAddress, i2cStartWrite, i2cRegister, i2cData);
        end
        stray = 0;
        repeat (15) begin
            @(negedge clock);
            if (done !== 1'b0 || busy !== 1'b0 || i2cStartWrite !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_errors++;
            $display("FAIL midrun_quiet: %0d active cycles after reset, expected 0", stray);
        end
    endtask

    initial begin
        for (int k = 0; k < 256; k++) nack_plan[k] = 0;
        for (int i = 0; i < NR; i++) rom_mem[i] = 16'hFFFF;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        test_reset();
        test_end_marker();
        test_basic_writes();
        test_delay();
        test_retry();
        test_retry_exhausted();
        test_timeout_ignored_start();
        test_full_table();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
